keccak_sponge_ctrl: RTL

KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

---
 rtl/keccak_pkg.sv | 28 ++
 rtl/keccak_pad.sv | 28 ++
 rtl/keccak_sponge_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak sponge controller: FSM states,
// padding bytes and rate derivation from digest width and lane exponent.
package keccak_pkg;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ABSORB,
    S_PAD,
    S_DONE
  } state_e;

  typedef enum logic {
    PAD_FULL,
    PAD_ONLY
  } pad_mode_e;

  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  function automatic int rate_bits(input int d, input int l);
    return 25 * (2 ** l) - 2 * d;
  endfunction

  function automatic int rate_bytes(input int d, input int l);
    return rate_bits(d, l) / 8;
  endfunction

endpackage

// File: rtl/keccak_pad.sv
// Combinational multi-rate padding of one rate block: keep bytes below k,
// drop the rest, then XOR the domain byte at k and the end marker at R-1.
module keccak_pad
  import keccak_pkg::*;
#(
  parameter int R = 172
) (
  input  logic [8*R-1:0] blk,
  input  logic [7:0]     k,
  input  pad_mode_e      mode,
  output logic [8*R-1:0] padded
);

  logic [7:0] kk;

  // Pad-only is a zero-length tail: no data bytes survive, domain byte at 0.
  assign kk = (mode == PAD_ONLY) ? 8'd0 : k;

  for (genvar i = 0; i < R; i++) begin : g_byte
    localparam logic [7:0] IDX = 8'(i);
    logic [7:0] ds;
    logic [7:0] fin;
    assign ds  = (IDX == kk) ? PAD_DS : 8'h00;
    assign fin = (i == R - 1) ? PAD_END : 8'h00;
    assign padded[8*i +: 8] = ((IDX < kk) ? blk[8*i +: 8] : 8'h00) ^ ds ^ fin;
  end

endmodule

// File: rtl/keccak_sponge_ctrl.sv
// Sponge absorb controller: feeds rate blocks to an external permutation core,
// applies final padding (inline or via an extra pad-only block) and holds the digest.
module keccak_sponge_ctrl
  import keccak_pkg::*;
#(
  parameter int d = 112,
  parameter int l = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [rate_bits(d, l)-1:0]   in_data,
  input  logic                         in_last,
  input  logic [7:0]                   in_bytes,
  output logic                         kc_enable,
  output logic                         kc_clear,
  output logic [rate_bits(d, l)-1:0]   kc_message,
  input  logic [d-1:0]                 kc_digest,
  output logic                         dig_valid,
  input  logic                         dig_ready,
  output logic [d-1:0]                 dig_data
);

  localparam int w = 2 ** l;
  localparam int b = 25 * w;
  localparam int c = 2 * d;
  localparam int r = b - c;
  localparam int R = rate_bytes(d, l);
  localparam logic [7:0] RB = 8'(R);

  state_e     state;
  logic [7:0] k;
  logic       last_short;
  pad_mode_e  pad_mode;
  logic [r-1:0] pad_out;

  // Oversized byte counts on a last beat saturate to a full block.
  assign k          = (in_bytes > RB) ? RB : in_bytes;
  assign last_short = in_last && (k < RB);
  assign pad_mode   = (state == S_PAD) ? PAD_ONLY : PAD_FULL;

  keccak_pad #(.R(R)) u_pad (
    .blk    (in_data),
    .k      (k),
    .mode   (pad_mode),
    .padded (pad_out)
  );

  assign in_ready   = (state == S_ABSORB);
  assign kc_clear   = (state == S_CLEAR);
  assign kc_enable  = (state == S_PAD) || ((state == S_ABSORB) && in_valid);
  assign kc_message = ((state == S_PAD) || last_short) ? pad_out : in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CLEAR;
      dig_valid <= 1'b0;
      dig_data  <= '0;
    end else begin
      case (state)
        S_CLEAR: state <= S_ABSORB;
        S_ABSORB: begin
          if (in_valid && in_last) begin
            if (last_short) begin
              state     <= S_DONE;
              dig_data  <= kc_digest;
              dig_valid <= 1'b1;
            end else begin
              state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          state     <= S_DONE;
          dig_data  <= kc_digest;
          dig_valid <= 1'b1;
        end
        S_DONE: begin
          if (dig_ready) begin
            state     <= S_CLEAR;
            dig_valid <= 1'b0;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
